// File: rtl/plic_prio_tree.sv
// rtl/plic_prio_tree.sv - pipelined PLIC priority tree with claim/complete; threshold compare gated by PLIC_PRIO_TREE_THRESHOLD_EN
module plic_prio_tree #(
    parameter int NUM_SRC    = 8,
    parameter int PRIO_W     = 3,
    parameter int ID_W       = 6,
    parameter int PIPE_EVERY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC-1:0]        src_pending,
    input  logic [NUM_SRC-1:0]        src_enable,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic [PRIO_W-1:0]         threshold,
    input  logic                      claim,
    input  logic                      complete,
    input  logic [ID_W-1:0]           complete_id,
    output logic                      irq,
    output logic [ID_W-1:0]           max_id,
    output logic [PRIO_W-1:0]         max_prio,
    output logic [ID_W-1:0]           claim_id,
    output logic                      claim_valid
);

    localparam int L  = $clog2(NUM_SRC);
    localparam int NL = 1 << L;
    localparam int PE = (PIPE_EVERY == 0) ? 1 : PIPE_EVERY;

    // Heap layout: node n combines children 2n and 2n+1; leaves sit at NL..2*NL-1.
    logic [PRIO_W-1:0] node_prio [1:2*NL-1];
    logic [ID_W-1:0]   node_id   [1:2*NL-1];

    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic               irq_q;
    logic [ID_W-1:0]    max_id_q;
    logic [PRIO_W-1:0]  max_prio_q;
    logic [ID_W-1:0]    claim_id_q;
    logic               claim_valid_q;

    for (genvar i = 0; i < NL; i++) begin : g_leaf
        if (i < NUM_SRC) begin : g_src
            logic eligible;
            assign eligible = src_pending[i] & src_enable[i] & ~in_service_q[i]
                            & (src_prio[i*PRIO_W +: PRIO_W] != '0);
            assign node_prio[NL+i] = eligible ? src_prio[i*PRIO_W +: PRIO_W] : '0;
            assign node_id[NL+i]   = eligible ? ID_W'(i + 1) : '0;
        end else begin : g_pad
            assign node_prio[NL+i] = '0;
            assign node_id[NL+i]   = '0;
        end
    end

    for (genvar d = 0; d < L; d++) begin : g_lvl
        for (genvar j = 0; j < (1 << d); j++) begin : g_node
            localparam int N = (1 << d) + j;
            localparam int H = L - d;
            logic              pick_right;
            logic [PRIO_W-1:0] prio_c;
            logic [ID_W-1:0]   id_c;

            // Left subtree always holds the lower IDs, so ties resolve to the left.
            assign pick_right = node_prio[2*N+1] > node_prio[2*N];
            assign prio_c     = pick_right ? node_prio[2*N+1] : node_prio[2*N];
            assign id_c       = pick_right ? node_id[2*N+1]   : node_id[2*N];

            if ((PIPE_EVERY != 0) && (H < L) && (H % PE == 0)) begin : g_reg
                logic [PRIO_W-1:0] prio_q;
                logic [ID_W-1:0]   id_q;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        prio_q <= '0;
                        id_q   <= '0;
                    end else begin
                        prio_q <= prio_c;
                        id_q   <= id_c;
                    end
                end
                assign node_prio[N] = prio_q;
                assign node_id[N]   = id_q;
            end else begin : g_comb
                assign node_prio[N] = prio_c;
                assign node_id[N]   = id_c;
            end
        end
    end

    logic root_irq;
`ifdef PLIC_PRIO_TREE_THRESHOLD_EN
    assign root_irq = node_prio[1] > threshold;
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold;
    assign root_irq = node_prio[1] != '0;
`endif

    logic svc_hit;
    logic grant;
    logic complete_ok;

    assign complete_ok = complete && (complete_id != '0) && (complete_id <= ID_W'(NUM_SRC));

    always_comb begin
        svc_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (max_id_q == ID_W'(i + 1)) svc_hit = in_service_q[i];
        end
    end

    // A winner still draining through the pipeline after its claim is refused.
    assign grant = claim & irq_q & ~svc_hit;

    always_comb begin
        in_service_d = in_service_q;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (complete_ok && (complete_id == ID_W'(i + 1))) in_service_d[i] = 1'b0;
            if (grant && (max_id_q == ID_W'(i + 1)))          in_service_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_service_q  <= '0;
            irq_q         <= 1'b0;
            max_id_q      <= '0;
            max_prio_q    <= '0;
            claim_id_q    <= '0;
            claim_valid_q <= 1'b0;
        end else begin
            in_service_q  <= in_service_d;
            irq_q         <= root_irq;
            max_id_q      <= node_id[1];
            max_prio_q    <= node_prio[1];
            claim_valid_q <= claim;
            if (claim) claim_id_q <= grant ? max_id_q : '0;
        end
    end

    assign irq         = irq_q;
    assign max_id      = max_id_q;
    assign max_prio    = max_prio_q;
    assign claim_id    = claim_id_q;
    assign claim_valid = claim_valid_q;

endmodule
